// File: rtl/c880_test_sequencer.sv
// c880_test_sequencer: LFSR-driven pattern sequencer that applies pseudo-random
// vectors to a suspect and a golden c880 netlist and scores their outputs.
//
// Ports
//   clk            : clock, all state updates on its rising edge
//   rst            : synchronous active-high reset
//   start          : single-cycle run request (honoured in IDLE only)
//   abort          : terminates a run in SEED/APPLY/CAPTURE
//   num_patterns   : number of patterns to apply, sampled on start
//   seed           : 60-bit LFSR seed, sampled on start (0 means all-ones)
//   dut_in         : 60-bit stimulus shared by suspect and golden netlists
//   dut_out        : 26-bit outputs of the suspect netlist
//   gold_out       : 26-bit outputs of the golden netlist
//   busy           : high whenever the sequencer is not in IDLE
//   done           : one-cycle pulse at run end
//   mismatch_cnt   : number of failing patterns (saturating)
//   first_fail_idx : index of the first failing pattern
//   first_fail_vld : first_fail_idx is valid
//   signature      : MISR of dut_out over all captures
//
// Optional feature: define SIG_COMPACT_EN to build the 26-bit output MISR;
// without it signature is tied to zero.

module c880_test_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [59:0]      seed,
    output logic [59:0]      dut_in,
    input  logic [25:0]      dut_out,
    input  logic [25:0]      gold_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             first_fail_vld,
    output logic [25:0]      signature
);

    localparam int unsigned IN_W  = 60;
    localparam int unsigned OUT_W = 26;
    localparam int unsigned SET_W = 4;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEED    = 3'd1;
    localparam logic [2:0] S_APPLY   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [IN_W-1:0]  lfsr;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] num_r;
    logic [SET_W-1:0] settle_cnt;

    logic [IN_W-1:0]  lfsr_nxt_c;
    logic             fail_c;
    logic             last_c;
    logic             settle_end_c;

    assign lfsr_nxt_c   = {lfsr[IN_W-2:0], lfsr[IN_W-1] ^ lfsr[IN_W-2]};
    assign fail_c       = |(dut_out ^ gold_out);
    assign last_c       = (idx == num_r - CNT_W'(1));
    assign settle_end_c = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = S_SEED;
            S_SEED:    next_state = (abort || num_r == '0) ? S_DONE : S_APPLY;
            S_APPLY: begin
                if (abort)             next_state = S_DONE;
                else if (settle_end_c) next_state = S_CAPTURE;
            end
            S_CAPTURE: next_state = (abort || last_c) ? S_DONE : S_APPLY;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            lfsr           <= '1;
            dut_in         <= '0;
            idx            <= '0;
            num_r          <= '0;
            settle_cnt     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != S_IDLE);
            done  <= (next_state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Seed and count are captured here; SEED applies them.
                        lfsr  <= (seed == '0) ? '1 : seed;
                        num_r <= num_patterns;
                    end
                end
                S_SEED: begin
                    idx            <= '0;
                    settle_cnt     <= '0;
                    mismatch_cnt   <= '0;
                    first_fail_idx <= '0;
                    first_fail_vld <= 1'b0;
                    if (next_state == S_APPLY) dut_in <= lfsr;
                end
                S_APPLY: begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                end
                S_CAPTURE: begin
                    // Scored even when abort coincides with the capture.
                    if (fail_c) begin
                        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                        if (!first_fail_vld) begin
                            first_fail_idx <= idx;
                            first_fail_vld <= 1'b1;
                        end
                    end
                    if (next_state == S_APPLY) begin
                        lfsr       <= lfsr_nxt_c;
                        dut_in     <= lfsr_nxt_c;
                        idx        <= idx + CNT_W'(1);
                        settle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SIG_COMPACT_EN
    // Galois MISR, x^26 + x^6 + x^2 + x + 1, absorbing dut_out on each capture
    localparam logic [OUT_W-1:0] MISR_POLY = 26'h000_0047;

    always_ff @(posedge clk) begin
        if (rst) begin
            signature <= '0;
        end else if (state == S_SEED) begin
            signature <= '0;
        end else if (state == S_CAPTURE) begin
            signature <= {signature[OUT_W-2:0], 1'b0}
                       ^ (signature[OUT_W-1] ? MISR_POLY : '0)
                       ^ dut_out;
        end
    end
`else
    assign signature = '0;
`endif

endmodule
